// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if: one valid/ready stream link.
//   valid  word present (driven by the sender)
//   data   WIDTH-bit word (driven by the sender)
//   ready  receiver accepts the word this cycle (driven by the receiver)
// Modports: master = sender side, slave = receiver side.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage register pipeline with valid/ready on both ends.
// Empty stages pull from the stage behind them even while the output is
// stalled, so bubbles collapse toward the output end.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   up     upstream link (slave): valid/data in, ready out
//   dn     downstream link (master): valid/data out, ready in
//   flush  synchronous clear of all valid bits and the count
//   count  number of occupied stages
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_reg_chain_if.slave      up,
  pipe_reg_chain_if.master     dn,
  input  logic                 flush,
  output logic [CW-1:0]        count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance when it is empty or the stage ahead advances.
  // The chain is rippled through a scalar so the vector has no self-loop.
  always_comb begin
    logic a;
    adv = '0;
    a = !v[DEPTH-1] | dn.ready;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = !v[i] | a;
      adv[i] = a;
    end
  end

  // in_ready depends only on state, out_ready and flush, never on in_valid.
  assign up.ready = adv[0] & !flush;
  assign in_xfer  = up.valid & up.ready;
  assign out_xfer = v[DEPTH-1] & dn.ready;

  assign dn.valid = v[DEPTH-1];
  assign dn.data  = d[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) begin
      // Data registers are left alone; only occupancy is cleared.
      v     <= '0;
      count <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= in_xfer;
        if (in_xfer) d[0] <= up.data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          // Empty incoming stage leaves old data in place so out_data is stable.
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       flush4, flush1;
  logic [2:0] count4;
  logic [0:0] count1;

  pipe_reg_chain_if #(.WIDTH(8)) up4 ();
  pipe_reg_chain_if #(.WIDTH(8)) dn4 ();
  pipe_reg_chain_if #(.WIDTH(1)) up1 ();
  pipe_reg_chain_if #(.WIDTH(1)) dn1 ();

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .up(up4), .dn(dn4), .flush(flush4), .count(count4)
  );

  pipe_reg_chain #(.WIDTH(1), .DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .up(up1), .dn(dn1), .flush(flush1), .count(count1)
  );

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       fl;
    logic       ir;
    logic       ov;
    logic [7:0] dout;
    int         cnt;
  } vec_t;

  vec_t tbl4[$];
  vec_t tbl1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // inputs: iv din ordy fl ; expected (before the edge): ir ov dout cnt
  task automatic add4(input logic iv, input logic [7:0] din, input logic ordy, input logic fl,
                      input logic ir, input logic ov, input logic [7:0] dout, input int cnt);
    vec_t t;
    t.iv = iv; t.din = din; t.ordy = ordy; t.fl = fl;
    t.ir = ir; t.ov = ov; t.dout = dout; t.cnt = cnt;
    tbl4.push_back(t);
  endtask

  task automatic add1(input logic iv, input logic din, input logic ordy, input logic fl,
                      input logic ir, input logic ov, input logic dout, input int cnt);
    vec_t t;
    t.iv = iv; t.din = {7'd0, din}; t.ordy = ordy; t.fl = fl;
    t.ir = ir; t.ov = ov; t.dout = {7'd0, dout}; t.cnt = cnt;
    tbl1.push_back(t);
  endtask

  initial begin
    // streaming, out_ready = 1: 11 appears after its 4th edge
    add4(1, 8'h11, 1, 0, 1, 0, 8'h00, 0);
    add4(1, 8'h22, 1, 0, 1, 0, 8'h00, 1);
    add4(1, 8'h33, 1, 0, 1, 0, 8'h00, 2);
    add4(0, 8'h00, 1, 0, 1, 0, 8'h00, 3);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h11, 3);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h22, 2);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    add4(0, 8'h00, 0, 0, 1, 0, 8'h33, 0);
    // backpressure fill 01..06, then drain
    add4(1, 8'h01, 0, 0, 1, 0, 8'h33, 0);
    add4(1, 8'h02, 0, 0, 1, 0, 8'h33, 1);
    add4(1, 8'h03, 0, 0, 1, 0, 8'h33, 2);
    add4(1, 8'h04, 0, 0, 1, 0, 8'h33, 3);
    add4(1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
    add4(1, 8'h06, 0, 0, 0, 1, 8'h01, 4);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h01, 4);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h02, 3);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h03, 2);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h04, 1);
    add4(0, 8'h00, 1, 0, 1, 0, 8'h04, 0);
    // bubble collapse: A0, 2 idle, B0, stalled output
    add4(1, 8'hA0, 0, 0, 1, 0, 8'h04, 0);
    add4(0, 8'h00, 0, 0, 1, 0, 8'h04, 1);
    add4(0, 8'h00, 0, 0, 1, 0, 8'h04, 1);
    add4(1, 8'hB0, 0, 0, 1, 0, 8'h04, 1);
    add4(0, 8'h00, 0, 0, 1, 1, 8'hA0, 2);
    add4(0, 8'h00, 0, 0, 1, 1, 8'hA0, 2);
    add4(0, 8'h00, 0, 0, 1, 1, 8'hA0, 2);
    // top up to full, then flush with in_valid and out_ready high
    add4(1, 8'hC0, 0, 0, 1, 1, 8'hA0, 2);
    add4(1, 8'hD0, 0, 0, 1, 1, 8'hA0, 3);
    add4(1, 8'hE0, 1, 1, 0, 1, 8'hA0, 4);
    add4(0, 8'h00, 1, 0, 1, 0, 8'hA0, 0);
    // fill, then full with simultaneous transfer
    add4(1, 8'h51, 0, 0, 1, 0, 8'hA0, 0);
    add4(1, 8'h52, 0, 0, 1, 0, 8'hA0, 1);
    add4(1, 8'h53, 0, 0, 1, 0, 8'hA0, 2);
    add4(1, 8'h54, 0, 0, 1, 0, 8'hA0, 3);
    add4(1, 8'h55, 1, 0, 1, 1, 8'h51, 4);
    add4(1, 8'h56, 1, 0, 1, 1, 8'h52, 4);
    add4(0, 8'h00, 0, 0, 0, 1, 8'h53, 4);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h53, 4);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h54, 3);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h55, 2);
    add4(0, 8'h00, 1, 0, 1, 1, 8'h56, 1);
    add4(0, 8'h00, 1, 0, 1, 0, 8'h56, 0);

    // DEPTH = 1, WIDTH = 1
    add1(1, 1, 0, 0, 1, 0, 0, 0);
    add1(1, 0, 0, 0, 0, 1, 1, 1);
    add1(1, 0, 1, 0, 1, 1, 1, 1);
    add1(1, 1, 1, 0, 1, 1, 0, 1);
    add1(0, 0, 1, 0, 1, 1, 1, 1);
    add1(1, 0, 1, 1, 0, 0, 1, 0);
    add1(0, 0, 0, 0, 1, 0, 1, 0);

    rst_n = 1'b0;
    up4.valid = 0; up4.data = '0; dn4.ready = 0; flush4 = 0;
    up1.valid = 0; up1.data = '0; dn1.ready = 0; flush1 = 0;

    // reset values
    #1;
    chk("rst out_valid", int'(dn4.valid), 0);
    chk("rst count", int'(count4), 0);
    chk("rst in_ready", int'(up4.ready), 1);
    chk("rst d1 out_valid", int'(dn1.valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // async reset with 3 words held
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      up4.valid = 1; up4.data = 8'h71 + 8'(k);
    end
    @(negedge clk);
    up4.valid = 0; up4.data = '0;
    @(negedge clk);
    #1;
    chk("held out_valid", int'(dn4.valid), 1);
    chk("held out_data", int'(dn4.data), 8'h71);
    chk("held count", int'(count4), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", int'(dn4.valid), 0);
    chk("async rst out_data", int'(dn4.data), 0);
    chk("async rst count", int'(count4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl4.size(); k++) begin
      @(negedge clk);
      up4.valid = tbl4[k].iv; up4.data = tbl4[k].din;
      dn4.ready = tbl4[k].ordy; flush4 = tbl4[k].fl;
      #1;
      chk($sformatf("d4[%0d] in_ready", k), int'(up4.ready), int'(tbl4[k].ir));
      chk($sformatf("d4[%0d] out_valid", k), int'(dn4.valid), int'(tbl4[k].ov));
      chk($sformatf("d4[%0d] out_data", k), int'(dn4.data), int'(tbl4[k].dout));
      chk($sformatf("d4[%0d] count", k), int'(count4), tbl4[k].cnt);
    end
    @(negedge clk);
    up4.valid = 0; dn4.ready = 0; flush4 = 0;

    for (int k = 0; k < tbl1.size(); k++) begin
      @(negedge clk);
      up1.valid = tbl1[k].iv; up1.data = tbl1[k].din[0];
      dn1.ready = tbl1[k].ordy; flush1 = tbl1[k].fl;
      #1;
      chk($sformatf("d1[%0d] in_ready", k), int'(up1.ready), int'(tbl1[k].ir));
      chk($sformatf("d1[%0d] out_valid", k), int'(dn1.valid), int'(tbl1[k].ov));
      chk($sformatf("d1[%0d] out_data", k), int'(dn1.data), int'(tbl1[k].dout));
      chk($sformatf("d1[%0d] count", k), int'(count1), tbl1[k].cnt);
    end
    @(negedge clk);
    up1.valid = 0; dn1.ready = 0; flush1 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
